// File: rtl/set_bit_scanner8.sv
// ---------------------------------------------------------------------------
// set_bit_scanner8
//
// Sequential companion to the 8-way OR reduction. A vector is captured on an
// input handshake. The block reports whether any bit was set, then emits the
// index of each set bit, lowest first, with one index per output handshake.
// Consumers use it to find which request/flag line raised the "any"
// indication.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in         in   [7:0] vector to scan, sampled on in_valid && in_ready
//   in_valid   in   producer offers `in`
//   in_ready   out  block can accept a vector (IDLE and reset low)
//   any        out  registered OR of the last captured vector
//   idx_out    out  [2:0] index of the lowest pending set bit
//   out_valid  out  idx_out is valid (high throughout SCAN)
//   out_ready  in   consumer accepts idx_out
//   last       out  idx_out is the final pending bit
//   done       out  one-cycle pulse when a scan completes, including empty
//   busy       out  high while scanning
// ---------------------------------------------------------------------------
module set_bit_scanner8 #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             any,
    output logic [IDX_W-1:0] idx_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last,
    output logic             done,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic               any_q, any_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   lowIdx;
    logic               oneLeft;

    // Priority encoder toward bit 0. The loop runs from the top down so that
    // the lowest set bit is the one assigned last.
    always_comb begin
        lowIdx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowIdx = i[IDX_W-1:0];
            end
        end
    end

    // Exactly one bit is pending when clearing the lowest set bit leaves
    // nothing behind.
    assign oneLeft = (mask_q != '0) && ((mask_q & (mask_q - 1'b1)) == '0);

    // The outputs depend only on registered state and mask, so out_ready has
    // no combinational path to out_valid or idx_out. in_ready is the only
    // output that looks at reset, so a producer cannot hand off a vector
    // while reset is held.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign busy      = (state_q == SCAN);
    assign out_valid = (state_q == SCAN);
    assign idx_out   = (state_q == SCAN) ? lowIdx : '0;
    assign last      = (state_q == SCAN) && oneLeft;
    assign any       = any_q;
    assign done      = done_q;

    // Next-state logic. IDLE captures a vector and jumps to SCAN when it is
    // non-empty. An empty vector completes immediately with a done pulse.
    // SCAN retires one bit per handshake and returns to IDLE on the final
    // one.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        any_d   = any_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d = in;
                    any_d  = |in;
                    if (in != '0) begin
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    mask_d[lowIdx] = 1'b0;
                    if (oneLeft) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wins over everything, including a scan in
    // progress. The pending mask is dropped and no done pulse is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            any_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            any_q   <= any_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_set_bit_scanner8.sv
// ---------------------------------------------------------------------------
// tb_set_bit_scanner8
//
// Directed testbench for set_bit_scanner8. Inputs change and outputs are
// sampled 1ns after each rising edge. Expected values are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_set_bit_scanner8;

    logic       clk;
    logic       reset;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic       any;
    logic [2:0] idx_out;
    logic       out_valid;
    logic       out_ready;
    logic       last;
    logic       done;
    logic       busy;

    int checkCount;
    int errorCount;

    set_bit_scanner8 dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .any       (any),
        .idx_out   (idx_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .done      (done),
        .busy      (busy)
    );

    // 10ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value and records the
    // result.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advances to 1ns past the next rising edge, where outputs have settled.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers a vector for one edge, then withdraws it.
    task automatic applyStimulus(input logic [7:0] vec);
        in       = vec;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        in         = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;

        // Test 1: reset followed by idle.
        stepCycle();
        stepCycle();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_any", any, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_idx", idx_out, 0);
        reset = 1'b0;
        #1;
        checkOutput("idle_in_ready", in_ready, 1);
        stepCycle();
        checkOutput("idle_in_ready2", in_ready, 1);
        checkOutput("idle_busy", busy, 0);

        // Test 2: sparse vector 1010_0100 with the consumer always ready.
        out_ready = 1'b1;
        applyStimulus(8'b1010_0100);
        checkOutput("sp_valid0", out_valid, 1);
        checkOutput("sp_idx0", idx_out, 2);
        checkOutput("sp_last0", last, 0);
        checkOutput("sp_any", any, 1);
        checkOutput("sp_busy", busy, 1);
        checkOutput("sp_in_ready", in_ready, 0);
        checkOutput("sp_done0", done, 0);
        stepCycle();
        checkOutput("sp_idx1", idx_out, 5);
        checkOutput("sp_last1", last, 0);
        stepCycle();
        checkOutput("sp_idx2", idx_out, 7);
        checkOutput("sp_last2", last, 1);
        checkOutput("sp_done2", done, 0);
        stepCycle();
        checkOutput("sp_done", done, 1);
        checkOutput("sp_valid_end", out_valid, 0);
        checkOutput("sp_in_ready_end", in_ready, 1);
        checkOutput("sp_any_hold", any, 1);
        stepCycle();
        checkOutput("sp_done_pulse", done, 0);

        // Test 3: empty vector.
        applyStimulus(8'h00);
        checkOutput("em_done", done, 1);
        checkOutput("em_valid", out_valid, 0);
        checkOutput("em_any", any, 0);
        checkOutput("em_busy", busy, 0);
        checkOutput("em_in_ready", in_ready, 1);
        stepCycle();
        checkOutput("em_done_pulse", done, 0);
        checkOutput("em_valid2", out_valid, 0);

        // Test 4: backpressure on 8'h81. An in_valid offered during SCAN is
        // ignored.
        out_ready = 1'b0;
        applyStimulus(8'h81);
        in       = 8'h0F;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_stall_idx", idx_out, 0);
            checkOutput("bp_stall_valid", out_valid, 1);
            checkOutput("bp_stall_last", last, 0);
            checkOutput("bp_stall_done", done, 0);
            stepCycle();
        end
        out_ready = 1'b1;
        checkOutput("bp_idx0", idx_out, 0);
        stepCycle();
        checkOutput("bp_idx7", idx_out, 7);
        checkOutput("bp_last7", last, 1);
        in_valid = 1'b0;
        stepCycle();
        checkOutput("bp_done", done, 1);
        checkOutput("bp_valid_end", out_valid, 0);
        stepCycle();
        checkOutput("bp_done_pulse", done, 0);

        // Test 5: full vector, then a back-to-back capture at the first
        // in_ready.
        applyStimulus(8'hFF);
        for (int i = 0; i < 8; i++) begin
            checkOutput("full_idx", idx_out, i);
            checkOutput("full_last", last, (i == 7) ? 1 : 0);
            checkOutput("full_valid", out_valid, 1);
            stepCycle();
        end
        checkOutput("full_done", done, 1);
        checkOutput("full_in_ready", in_ready, 1);
        applyStimulus(8'h10);
        checkOutput("b2b_idx", idx_out, 4);
        checkOutput("b2b_last", last, 1);
        checkOutput("b2b_any", any, 1);
        checkOutput("b2b_done", done, 0);
        stepCycle();
        checkOutput("b2b_done_end", done, 1);
        stepCycle();

        // Test 6: reset asserted in the middle of a scan.
        applyStimulus(8'hF0);
        checkOutput("mr_idx4", idx_out, 4);
        stepCycle();
        checkOutput("mr_idx5", idx_out, 5);
        reset = 1'b1;
        stepCycle();
        checkOutput("mr_valid", out_valid, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_any", any, 0);
        checkOutput("mr_done", done, 0);
        checkOutput("mr_in_ready_rst", in_ready, 0);
        reset = 1'b0;
        #1;
        checkOutput("mr_in_ready", in_ready, 1);
        stepCycle();
        checkOutput("mr_no_done", done, 0);
        applyStimulus(8'h02);
        checkOutput("mr_idx1", idx_out, 1);
        checkOutput("mr_last1", last, 1);
        checkOutput("mr_any1", any, 1);
        stepCycle();
        checkOutput("mr_done_end", done, 1);
        checkOutput("mr_valid_end", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/set_bit_scanner8.md
Name: set_bit_scanner8

Overview:
- Sequential expander for the 8-way OR reduction. It captures an 8-bit vector and reports whether any bit is set.
- It then emits the index of each set bit, lowest first, one per valid/ready handshake.
- It sits beside the Or8Way-style summary logic. Consumers use it to find which of eight request/flag lines caused the "any" indication, such as the interrupt or peripheral-select scanning feeding the CPU/memory map.

Parameters:
- WIDTH, 8, number of input lines. Fixed at 8 for this block; the port widths below assume 8.
- IDX_W, 3, width of the emitted index. Must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  8  vector to scan; sampled only on an input handshake.
- in_valid  input  1  producer offers `in`.
- in_ready  output  1  block can accept a vector; high only in IDLE with reset low.
- any  output  1  registered OR of the last captured vector.
- idx_out  output  3  index of the lowest set bit still pending.
- out_valid  output  1  idx_out is valid.
- out_ready  input  1  consumer accepts idx_out.
- last  output  1  the current idx_out is the final pending bit.
- done  output  1  one-cycle pulse when a scan completes, including the empty case.
- busy  output  1  high while in SCAN.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - State becomes IDLE and the mask register becomes 8'h00.
  - any=0, done=0, out_valid=0, busy=0, last=0, idx_out=3'd0.
  - in_ready is forced to 0 while reset is high.
  - Reset overrides everything, including a scan in progress. The pending mask is discarded and no done pulse is produced.
- State machine: IDLE, SCAN.
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid is high at an edge, the block loads mask<=in and any<=|in.
  - If in != 0, the next state is SCAN.
  - If in == 0, the block stays in IDLE and done=1 for exactly the next cycle.
- SCAN outputs:
  - in_ready=0, busy=1, out_valid=1.
  - idx_out = position of the lowest set bit of mask (priority toward bit 0).
  - last = 1 when mask has exactly one bit set.
  - These outputs are combinational from the registered mask and state only. There is no combinational path from out_ready to out_valid or idx_out.
- SCAN on a handshake (out_valid && out_ready at an edge):
  - The block clears mask[idx_out].
  - If last=1, the next state is IDLE, and done=1 for the next cycle.
- SCAN without out_ready:
  - mask, idx_out and last hold stable for any number of stall cycles.
- Latency:
  - The first index is valid in the cycle after the capture edge.
  - The scan then emits one index per cycle when out_ready is held high.
  - A vector with N set bits completes in N handshake cycles.
  - A new vector can be accepted in the cycle after done rises; there is no overlap with the final handshake.
- any holds the value of the last capture until the next capture or reset. It is not cleared as mask drains.
- in_valid during SCAN is ignored; the producer must hold the vector until in_ready returns.
- in=8'hFF emits 0..7 in order, with last high only on index 7.
- in=8'h80 emits the single index 7 with last=1.
- done and out_valid are never high in the same cycle.

Test Plan:
- Reset then idle: hold reset for 2 cycles, then release -> any=0, out_valid=0, done=0, busy=0; in_ready=1 in the first cycle after release.
- Sparse vector, consumer always ready: in=8'b1010_0100 with one in_valid pulse -> idx_out sequence 2,5,7 on 3 consecutive cycles, last=1 only with 7, any=1, done pulses once in the following cycle, in_ready returns high the same cycle as done.
- Empty vector: in=8'h00 -> no out_valid at all, any=0, done=1 for exactly one cycle after capture, block remains in IDLE.
- Backpressure: in=8'h81, with out_ready low for 4 cycles then high -> idx_out=0 held stable for 4 cycles, then 7 with last=1, then done; in_valid asserted during SCAN with in=8'h0F is not captured.
- Full vector, then back-to-back capture: in=8'hFF -> indices 0..7 in 8 cycles; capture 8'h10 at the first in_ready -> idx_out=4 with last=1, any stays 1.
- Reset mid-scan: in=8'hF0, reset asserted after index 5 is emitted -> next cycle out_valid=0, busy=0, any=0, no done pulse; a subsequent capture of 8'h02 yields index 1 only.
